// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: request/grant imem port with multiple in-flight
// fetches, an in-order prefetch FIFO toward decode, and redirect flush/discard.
module fetch_prefetch_unit #(
  parameter int unsigned     DATA_WIDTH      = 32,
  parameter int unsigned     ADDR_WIDTH      = 32,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  d_valid,
  input  logic                  d_ready,
  output logic [DATA_WIDTH-1:0] d_instr,
  output logic [ADDR_WIDTH-1:0] d_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [2:0]  MAXO = 3'(MAX_OUTSTANDING);

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_resp_pc;
  logic [ADDR_WIDTH-1:0] r_pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] r_instr_mem [DEPTH];
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic [2:0]            r_outst;
  logic [2:0]            r_discard;

  logic                  w_credit_ok;
  logic                  w_grant;
  logic                  w_rsp;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_redir_pc;

  // Counting in-flight fetches against FIFO space means a push can never overflow.
  assign w_credit_ok = (32'(r_count) + 32'(r_outst)) < DEPTH;
  assign imem_req    = !rst && !redirect && (r_outst < MAXO) && w_credit_ok;
  assign imem_addr   = r_fetch_pc;
  assign w_grant     = imem_req && imem_gnt;
  assign w_rsp       = imem_rvalid && (r_outst != '0);
  assign w_push      = w_rsp && (r_discard == '0) && !redirect;
  assign d_valid     = (r_count != '0) && !redirect;
  assign w_pop       = d_valid && d_ready;
  assign d_instr     = r_instr_mem[r_rd_ptr];
  assign d_pc        = r_pc_mem[r_rd_ptr];
  assign w_redir_pc  = redirect_pc & ~ADDR_WIDTH'(3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_outst    <= '0;
      r_discard  <= '0;
    end else if (redirect) begin
      // Every request still in flight now belongs to the old path; the
      // same-cycle response (if any) is consumed and dropped here.
      r_fetch_pc <= w_redir_pc;
      r_resp_pc  <= w_redir_pc;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_outst    <= r_outst - 3'(w_rsp);
      r_discard  <= r_outst - 3'(w_rsp);
    end else begin
      r_outst <= r_outst + 3'(w_grant) - 3'(w_rsp);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_grant)
        r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
      if (w_rsp && (r_discard != '0))
        r_discard <= r_discard - 3'd1;
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + PW'(1);
        r_resp_pc <= r_resp_pc + ADDR_WIDTH'(4);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_resp_pc;
      r_instr_mem[r_wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: in-order latency memory, epoch-tagged stream
// model of the expected decode sequence, directed scenarios plus random traffic.
module tb_fetch_prefetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_instr;
  logic [31:0] d_pc;

  fetch_prefetch_unit #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .d_valid(d_valid),
    .d_ready(d_ready),
    .d_instr(d_instr),
    .d_pc(d_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    int unsigned ep;
  } req_t;

  req_t        memq[$];
  logic [31:0] expq[$];
  int unsigned cyc, epoch, lat;
  logic [31:0] exp_fetch;
  bit          rdy, gnt_en, do_redir, inj_err, popped;
  logic [31:0] rpc, last_pop_pc;
  int unsigned n_grant, n_pop;
  int          vectors, miscompares;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1: drive inputs, check at posedge+2, advance the model.
  task automatic cycle();
    bit          exp_req, exp_dv;
    logic [31:0] e;
    req_t        r;
    redirect    = do_redir;
    redirect_pc = rpc;
    d_ready     = rdy;
    imem_gnt    = gnt_en;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(memq[0].addr);
    end else if (inj_err && memq.size() == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
    exp_req = !do_redir && (memq.size() < MAXO) && ((expq.size() + memq.size()) < DEPTH);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, exp_fetch);
    exp_dv = (expq.size() > 0) && !do_redir;
    chk("d_valid", 32'(d_valid), 32'(exp_dv));
    popped = 1'b0;
    if (exp_dv && rdy) begin
      e = expq.pop_front();
      chk("d_pc", d_pc, e);
      chk("d_instr", d_instr, mem_word(e));
      n_pop++;
      popped      = 1'b1;
      last_pop_pc = e;
    end
    if (imem_rvalid && memq.size() > 0) begin
      r = memq.pop_front();
      if (!do_redir && r.ep == epoch) expq.push_back(r.addr);
    end
    if (do_redir) begin
      epoch++;
      expq.delete();
      exp_fetch = {rpc[31:2], 2'b00};
    end
    if (imem_req && imem_gnt) begin
      r.addr = imem_addr;
      r.due  = cyc + lat;
      r.ep   = epoch;
      memq.push_back(r);
      exp_fetch = exp_fetch + 32'd4;
      n_grant++;
    end
    cyc++;
    do_redir = 1'b0;
    inj_err  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst         = 1'b1;
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    redirect    = 1'b0;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_d_instr", d_instr, 32'd0);
    chk("rst_d_pc", d_pc, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    memq.delete();
    expq.delete();
    epoch++;
    exp_fetch = RESET_PC;
  endtask

  task automatic wait_pop(input string tag, input logic [31:0] exp_pc);
    int unsigned n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!popped && n < 30);
    chk({tag, "_seen"}, 32'(popped), 32'd1);
    chk(tag, last_pop_pc, exp_pc);
  endtask

  initial begin
    rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; d_ready = 1'b0;
    vectors = 0; miscompares = 0; cyc = 0; epoch = 0; lat = 1;
    rdy = 1'b1; gnt_en = 1'b1; do_redir = 1'b0; inj_err = 1'b0; rpc = '0;
    n_grant = 0; n_pop = 0; popped = 1'b0; last_pop_pc = '0; exp_fetch = RESET_PC;

    do_reset();
    n_pop = 0;
    repeat (12) cycle();
    chk("zero_wait_pops", n_pop, 32'd10);

    lat = 3;
    repeat (30) cycle();

    lat = 1;
    do_reset();
    rdy = 1'b0;
    n_grant = 0;
    repeat (10) cycle();
    chk("bp_grants", n_grant, 32'd4);
    chk("bp_req_low", 32'(imem_req), 32'd0);
    rdy = 1'b1;
    n_pop = 0;
    repeat (4) cycle();
    chk("bp_release_pops", n_pop, 32'd4);
    chk("bp_last_pc", last_pop_pc, 32'd12);

    lat = 3;
    repeat (6) cycle();
    do_redir = 1'b1; rpc = 32'h0000_0104;
    cycle();
    wait_pop("redir_104", 32'h0000_0104);

    lat = 1;
    repeat (6) cycle();
    do_redir = 1'b1; rpc = 32'h0000_0203;
    cycle();
    wait_pop("redir_203", 32'h0000_0200);

    do_redir = 1'b1; rpc = 32'hFFFF_FFF8;
    cycle();
    repeat (8) cycle();

    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      gnt_en = ($urandom_range(0, 3) != 0);
      rdy    = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) begin
        do_redir = 1'b1;
        rpc = ($urandom_range(0, 1) == 1) ? 32'($urandom) : (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)));
      end
      inj_err = ($urandom_range(0, 29) == 0);
      cycle();
    end

    lat = 3; gnt_en = 1'b1; rdy = 1'b1;
    begin
      int unsigned n;
      n = 0;
      repeat (4) cycle();
      while (memq.size() != 2 && n < 10) begin
        cycle();
        n++;
      end
    end
    do_reset();
    wait_pop("post_reset_first", RESET_PC);
    repeat (10) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
